// File: rtl/cla_share_arbiter.sv
// cla_share_arbiter: round-robin time-sharing of one 24-bit carry-lookahead adder among NUM_REQ requesters.
// Optional `CLA_SHARE_CHAIN_EN adds locked multi-word chained adds via req_chain.
module carryLookAheadAdder (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic        cin,
    output logic [23:0] result,
    output logic        cout
);
    logic [23:0] g, p;
    logic [5:0]  gg, gp;
    logic [24:0] c;
    assign g = a & b;
    assign p = a ^ b;
    for (genvar j = 0; j < 6; j++) begin : grp
        assign gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (&p[4*j+3 -: 2] & g[4*j+1]) | (&p[4*j+3 -: 3] & g[4*j]);
        assign gp[j] = &p[4*j +: 4];
    end
    // carries inside each 4-bit group are fully expanded; group carries chain through gg/gp
    always_comb begin
        c = '0;
        c[0] = cin;
        for (int k = 0; k < 6; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (&p[4*k +: 2] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (&p[4*k+1 +: 2] & g[4*k]) | (&p[4*k +: 3] & c[4*k]);
            c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
        end
    end
    assign result = p ^ c[23:0];
    assign cout = c[24];
endmodule

module cla_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [24*NUM_REQ-1:0]   req_a,
    input  logic [24*NUM_REQ-1:0]   req_b,
    input  logic [NUM_REQ-1:0]      req_cin,
`ifdef CLA_SHARE_CHAIN_EN
    input  logic [NUM_REQ-1:0]      req_chain,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [23:0]             rsp_result,
    output logic                    rsp_cout
);
    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [ID_W:0]   NR   = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ - 1);
    logic [0:0]      state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d, id_q, gnt_id;
    logic [ID_W:0]   idx;
    logic [23:0]     result_q, op_a, op_b, sum;
    logic            cout_q, op_cin, sum_cout, gnt_any, can_issue, accept, chain_acc;
    logic [NUM_REQ-1:0] gnt_vec;
`ifdef CLA_SHARE_CHAIN_EN
    logic            lock_q, lock_d, carry_q, carry_d;
    logic [ID_W-1:0] lock_id_q, lock_id_d;
`endif
    always_comb begin
        gnt_any = 1'b0;
        gnt_id = ptr_q;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(k);
            idx = (idx >= NR) ? idx - NR : idx;
            if (req_valid[idx[ID_W-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id = idx[ID_W-1:0];
            end
        end
`ifdef CLA_SHARE_CHAIN_EN
        // a locked requester owns the adder even while its valid is low
        if (lock_q) begin
            gnt_any = 1'b1;
            gnt_id = lock_id_q;
        end
`endif
    end
    assign rsp_valid = (state_q == FULL);
    assign can_issue = !rsp_valid | rsp_ready;
    assign gnt_vec = gnt_any ? (NUM_REQ'(1) << gnt_id) : '0;
    assign req_ready = gnt_vec & {NUM_REQ{can_issue & !rst}};
    assign accept = |(req_valid & req_ready);
    always_comb begin
        op_a = '0;
        op_b = '0;
        op_cin = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                op_a = req_a[24*k +: 24];
                op_b = req_b[24*k +: 24];
                op_cin = req_cin[k];
            end
        end
`ifdef CLA_SHARE_CHAIN_EN
        if (lock_q) op_cin = carry_q;
`endif
    end
    carryLookAheadAdder u_cla (
        .a      (op_a),
        .b      (op_b),
        .cin    (op_cin),
        .result (sum),
        .cout   (sum_cout)
    );
`ifdef CLA_SHARE_CHAIN_EN
    assign chain_acc = accept & req_chain[gnt_id];
    assign lock_d = accept ? req_chain[gnt_id] : lock_q;
    assign lock_id_d = accept ? gnt_id : lock_id_q;
    assign carry_d = chain_acc ? sum_cout : carry_q;
`else
    assign chain_acc = 1'b0;
`endif
    assign state_d = accept ? FULL : (rsp_ready ? EMPTY : state_q);
    assign ptr_d = (accept & !chain_acc) ? ((gnt_id == LAST) ? '0 : gnt_id + 1'b1) : ptr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q <= '0;
            id_q <= '0;
            result_q <= '0;
            cout_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            if (accept) begin
                id_q <= gnt_id;
                result_q <= sum;
                cout_q <= sum_cout;
            end
        end
    end
`ifdef CLA_SHARE_CHAIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q <= 1'b0;
            lock_id_q <= '0;
            carry_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            lock_id_q <= lock_id_d;
            carry_q <= carry_d;
        end
    end
`endif
    assign rsp_id = id_q;
    assign rsp_result = result_q;
    assign rsp_cout = cout_q;
endmodule

// File: doc/cla_share_arbiter.md
# cla_share_arbiter

Round-robin scheduler that time-shares one 24-bit carry-lookahead adder (`carryLookAheadAdder`: a, b, cin → result, cout) among NUM_REQ requesters, e.g. the FP adder's mantissa-align, normalise and rounding stages. Each requester has a valid/ready request port. Results come back through a single registered response port that carries the requester ID, with one cycle of latency and full backpressure. The block instantiates the adder internally, so no requester drives it directly.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- ID_W, 2: width of rsp_id; must satisfy 2^ID_W ≥ NUM_REQ.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant/accept; one-hot or zero.
- req_a  in  24*NUM_REQ  operand A; requester i occupies bits [24i+23:24i].
- req_b  in  24*NUM_REQ  operand B, same packing as req_a.
- req_cin  in  NUM_REQ  carry-in per requester.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that issued the response.
- rsp_result  out  24  sum, (a+b+cin) mod 2^24.
- rsp_cout  out  1  carry-out, bit 24 of a+b+cin.

## Operation
- Output buffer: one entry, made of the rsp_* registers.
- `can_issue` = !rsp_valid | rsp_ready.
- Arbitration is combinational:
  - Grant the first i with req_valid[i]=1, scanning from pointer `ptr` upward, modulo NUM_REQ.
  - req_ready[i] = grant[i] & can_issue & !rst.
- A transfer is accepted when req_valid[i] & req_ready[i].
- On an accepted transfer:
  - Adder inputs come from the granted slice.
  - rsp_result, rsp_cout and rsp_id are loaded, and rsp_valid goes to 1.
  - ptr becomes (i+1) mod NUM_REQ.
- If rsp_valid & rsp_ready and nothing is accepted, rsp_valid goes to 0.
- FSM on the buffer:
  - EMPTY → FULL on accept.
  - FULL → FULL on accept while rsp_ready=1 (back-to-back).
  - FULL → EMPTY on rsp_ready=1 with no accept.
  - FULL holds while rsp_ready=0. The rsp_* outputs stay stable and all req_ready are 0.
- ptr only advances on accept. An idle or stalled cycle leaves ptr unchanged.
- A requester that withdraws valid before it is granted loses nothing: its turn simply comes round again.
- Widths: the adder result is exactly 24 bits and cout is its bit 24. There is no saturation.

## Timing
- Latency: accept at edge N gives rsp_valid=1 after edge N, so the result is visible in cycle N+1.
- Throughput: one operation per cycle while rsp_ready=1.
- Reset takes effect at the first rising edge with rst=1. After that edge:
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_cout=0.
  - ptr=0.
  - Lock and carry state are cleared.
- req_ready=0 in every cycle where rst=1.
- Reset during FULL discards the buffered response; there is no flush handshake.
- Fairness: each continuously-valid requester is granted within NUM_REQ accepts.
- Simultaneous rsp_ready and a new request: the old response retires and the new one loads on the same edge.

## Configuration
- Macro: `CLA_SHARE_CHAIN_EN`. It enables multi-word chained adds, e.g. 48-bit operations split into 24-bit halves.
- With the macro defined:
  - Extra port: req_chain, input, NUM_REQ bits.
  - An accepted op with req_chain[i]=1 stores rsp_cout into `carry_q` and sets lock to requester i.
  - While locked, only requester i can be granted, even if its valid is low. That op uses cin=carry_q and ignores req_cin[i].
  - The lock releases on an accepted op from i with req_chain[i]=0. That op also uses carry_q.
  - ptr advances only on release.
- Without the macro: no req_chain port, no lock, and cin is always req_cin.

## Test plan
- **Single op, ready high:** req0 with a=0xFFFFFF, b=0x000001, cin=0. Expect rsp_valid one cycle later with rsp_result=0x000000, rsp_cout=1, rsp_id=0.
- **Round-robin:** all four requesters hold valid with rsp_ready=1. Grants must run 0,1,2,3,0,… with one response per cycle and rsp_id matching.
- **Backpressure:** hold rsp_ready=0 for 3 cycles with a FULL buffer. rsp_* must stay stable and req_ready must be 0. Release, then check the next op (a=0x123456, b=0x111111, cin=1) returns 0x234568.
- **Reset mid-operation:** assert rst while FULL, with req2 pending. The next cycle must show rsp_valid=0, ptr=0, and req0 granted first after rst falls.
- **Chain (CLA_SHARE_CHAIN_EN):** req1 sends low word 0x800000+0x800000 with chain=1, then high word 0x000001+0x000000 with chain=0, while req3 stays valid throughout. Expect responses 0x000000 (cout=1) then 0x000002. req3 must not be granted between the two words.
- **Starvation bound:** req0 streams continuously while req2 is asserted. req2 must be granted within NUM_REQ accepts.
